// File: rtl/set_serial.sv
// Digit-serial compare-and-set unit: computes a - b one DIGIT-bit slice per cycle, then
// derives the SEQ/SNE/SLT/SGT/SLE/SGE/SLTU/SGEU bit. Optional: SET_SERIAL_EARLY_EXIT_EN.
module set_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [0:WIDTH-1] req_a,
    input  logic [0:WIDTH-1] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_set,
    output logic             busy
);

    localparam int unsigned NumDigits = WIDTH / DIGIT;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              zero_q, zero_d, carry_q, carry_d;
    logic              a_msb_q, a_msb_d, nb_msb_q, nb_msb_d, d_msb_q, d_msb_d;

    logic [WIDTH-1:0]  a_cap, b_cap;
    logic [DIGIT-1:0]  slice_a, slice_nb, diff;
    logic [DIGIT:0]    sum;
    logic              eq, lt, ltu, ovf, set_bit;

    // Ports are declared [0:WIDTH-1] with index 0 as LSB; internal vectors use [WIDTH-1:0].
    always_comb begin
        a_cap = '0;
        b_cap = '0;
        for (int i = 0; i < WIDTH; i++) begin
            a_cap[i] = req_a[i];
            b_cap[i] = req_b[i];
        end
    end

    // Operands shift right each CALC cycle so the active slice is always at the bottom.
    always_comb begin
        slice_a  = a_q[DIGIT-1:0];
        slice_nb = ~b_q[DIGIT-1:0];
        sum      = {1'b0, slice_a} + {1'b0, slice_nb} + (DIGIT+1)'(carry_q);
        diff     = sum[DIGIT-1:0];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        a_msb_d  = a_msb_q;
        nb_msb_d = nb_msb_q;
        d_msb_d  = d_msb_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    a_d     = a_cap;
                    b_d     = b_cap;
                    op_d    = req_op;
                    cnt_d   = '0;
                    zero_d  = 1'b1;
                    carry_d = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                cnt_d    = cnt_q + CntW'(1);
                zero_d   = zero_q & (diff == '0);
                carry_d  = sum[DIGIT];
                a_msb_d  = slice_a[DIGIT-1];
                nb_msb_d = slice_nb[DIGIT-1];
                d_msb_d  = diff[DIGIT-1];
                if (cnt_q == CntW'(NumDigits - 1)) begin
                    state_d = StDone;
                end
`ifdef SET_SERIAL_EARLY_EXIT_EN
                // Any nonzero digit settles EQ; remaining digits cannot change SEQ/SNE.
                if (op_q[2:1] == 2'b00 && diff != '0) begin
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            nb_msb_q <= 1'b0;
            d_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            a_msb_q  <= a_msb_d;
            nb_msb_q <= nb_msb_d;
            d_msb_q  <= d_msb_d;
        end
    end

    // Result is derived from retained flags, so it is stable for the whole DONE state.
    always_comb begin
        eq  = zero_q;
        ovf = (a_msb_q == nb_msb_q) & (d_msb_q != a_msb_q);
        lt  = d_msb_q ^ ovf;
        ltu = ~carry_q;
        unique case (op_q)
            3'b000:  set_bit = eq;
            3'b001:  set_bit = ~eq;
            3'b010:  set_bit = lt;
            3'b011:  set_bit = ~lt & ~eq;
            3'b100:  set_bit = lt | eq;
            3'b101:  set_bit = ~lt;
            3'b110:  set_bit = ltu;
            default: set_bit = ~ltu;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign rsp_set   = {{(WIDTH-1){1'b0}}, set_bit};

endmodule

// File: tb/tb_set_serial.sv
// Directed bench for set_serial at default parameters; expected latency follows
// SET_SERIAL_EARLY_EXIT_EN when it is defined for the build.
module tb_set_serial;

    localparam int unsigned Width = 32;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [0:Width-1] req_a;
    logic [0:Width-1] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [Width-1:0] rsp_set;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    set_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_set   (rsp_set),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Numeric value -> port vector whose index 0 is the LSB.
    function automatic logic [0:Width-1] to_port(input logic [Width-1:0] v);
        logic [0:Width-1] p;
        for (int i = 0; i < Width; i++) p[i] = v[i];
        return p;
    endfunction

    function automatic int first_diff(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 8; k++) begin
            if (a[4*k +: 4] != b[4*k +: 4]) return k + 1;
        end
        return 8;
    endfunction

    // Called #1 after an edge with the DUT idle and rsp_ready high.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_set);
        int lat;
        int exp_lat;
        exp_lat = 8;
`ifdef SET_SERIAL_EARLY_EXIT_EN
        if (op == 3'b000 || op == 3'b001) exp_lat = first_diff(a, b);
`endif
        req_valid = 1'b1;
        req_op    = op;
        req_a     = to_port(a);
        req_b     = to_port(b);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_a     = to_port(~a);
        req_b     = to_port(b ^ 32'h5A5A_0F0F);
        check({tag, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " set"}, rsp_set, exp_set);
        @(posedge clk);
        #1;
        check({tag, " ready after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_set", rsp_set, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("seq equal", 3'b000, 32'h1234_5678, 32'h1234_5678, 32'd1);
        run_op("slt -1<1", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1);
        run_op("sltu -1<1", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0);
        run_op("sgt ovf", 3'b011, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1);
        run_op("sle ovf", 3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("sne 1,0", 3'b001, 32'h0000_0001, 32'h0000_0000, 32'd1);
        run_op("seq digit1", 3'b000, 32'h0000_0010, 32'h0000_0000, 32'd0);
        run_op("sge equal", 3'b101, 32'h0000_0005, 32'h0000_0005, 32'd1);
        run_op("sltu 0<max", 3'b110, 32'h0000_0000, 32'hFFFF_FFFF, 32'd1);
        run_op("sgeu equal", 3'b111, 32'h0000_0003, 32'h0000_0003, 32'd1);
        run_op("sgt equal", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'd0);
        run_op("sne top", 3'b001, 32'h1000_0000, 32'h0000_0000, 32'd1);

        // Backpressure in DONE with req_valid held high throughout.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 3'b010;
        req_a     = to_port(32'h0000_0002);
        req_b     = to_port(32'h0000_0003);
        @(posedge clk);
        #1;
        seen = 0;
        while (!rsp_valid && seen < 20) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check("bp latency", 32'(seen), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_set", rsp_set, 32'd1);
            check("bp req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp handshake idle", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset during the third CALC cycle discards the request.
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = to_port(32'hCAFE_F00D);
        req_b     = to_port(32'hCAFE_F00D);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset req_ready", 32'(req_ready), 32'd1);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("no rsp after reset", 32'(seen), 32'd0);

        run_op("post reset slt", 3'b010, 32'h8000_0000, 32'h0000_0000, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
